// File: rtl/hazard_scoreboard.sv
// Load-use stall and EX forward-select control for the pipelined MIPS cores.
// A DEPTH-slot shift scoreboard tracks in-flight register writes past ID.
module hazard_scoreboard #(
  parameter int RW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FLUSH_N    = 2,
  parameter int CW         = 16,
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic [RW-1:0] id_rd,
  input  logic          id_we,
  input  logic          id_load,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_a,
  output logic [SW-1:0] fwd_b,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] fwd_cnt
);

  logic [DEPTH:1] r_v;
  logic [DEPTH:1] r_we;
  logic [DEPTH:1] r_ld;
  logic [RW-1:0]  r_rd [1:DEPTH];
  logic [SW-1:0]  r_fwd_a;
  logic [SW-1:0]  r_fwd_b;
  logic [CW-1:0]  r_stall_cnt;
  logic [CW-1:0]  r_fwd_cnt;

  logic [SW-1:0]  w_s1;
  logic [SW-1:0]  w_s2;
  logic           w_ld1;
  logic           w_ld2;
  logic           w_hz1;
  logic           w_hz2;
  logic           w_stall;
  logic           w_go;
  logic [SW-1:0]  w_nf_a;
  logic [SW-1:0]  w_nf_b;
  logic [1:0]     w_nfwd;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cnt,
                                            input logic [1:0]    inc);
    logic [CW:0] sum;
    sum = {1'b0, cnt} + (CW+1)'(inc);
    return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
  endfunction

  // Scan oldest to youngest so the youngest matching slot wins.
  always_comb begin
    w_s1  = '0;
    w_s2  = '0;
    w_ld1 = 1'b0;
    w_ld2 = 1'b0;
    for (int s = DEPTH; s >= 1; s--) begin
      if (r_v[s] && r_we[s] && (r_rd[s] == id_rs1) && (id_rs1 != '0)) begin
        w_s1  = SW'(s);
        w_ld1 = r_ld[s];
      end
      if (r_v[s] && r_we[s] && (r_rd[s] == id_rs2) && (id_rs2 != '0)) begin
        w_s2  = SW'(s);
        w_ld2 = r_ld[s];
      end
    end
  end

  assign w_hz1   = id_use1 && (w_s1 != '0) && w_ld1 && (w_s1 < SW'(LOAD_STAGE));
  assign w_hz2   = id_use2 && (w_s2 != '0) && w_ld2 && (w_s2 < SW'(LOAD_STAGE));
  assign w_stall = id_valid && !flush && (w_hz1 || w_hz2);
  assign w_go    = id_valid && !w_stall && !flush;

  // Producer in slot s will sit in slot s+1 once the consumer reaches EX.
  assign w_nf_a = (w_go && id_use1 && (w_s1 != '0) && (w_s1 < SW'(DEPTH)))
                  ? w_s1 + SW'(1) : '0;
  assign w_nf_b = (w_go && id_use2 && (w_s2 != '0) && (w_s2 < SW'(DEPTH)))
                  ? w_s2 + SW'(1) : '0;
  assign w_nfwd = {1'b0, |w_nf_a} + {1'b0, |w_nf_b};

  // ---- scoreboard payload: shifts unconditionally, qualified by r_v ----
  always_ff @(posedge clk) begin
    r_we[1] <= id_we;
    r_ld[1] <= id_load;
    r_rd[1] <= id_rd;
    for (int s = 2; s <= DEPTH; s++) begin
      r_we[s] <= r_we[s-1];
      r_ld[s] <= r_ld[s-1];
      r_rd[s] <= r_rd[s-1];
    end
  end

  // ---- scoreboard valids, forward selects and counters ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v         <= '0;
      r_fwd_a     <= '0;
      r_fwd_b     <= '0;
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      r_v[1] <= w_go;
      for (int s = 2; s <= DEPTH; s++) begin
        r_v[s] <= r_v[s-1] && !(flush && (s - 1 <= FLUSH_N));
      end
      r_fwd_a     <= w_nf_a;
      r_fwd_b     <= w_nf_b;
      r_stall_cnt <= sat_add(r_stall_cnt, {1'b0, w_stall});
      r_fwd_cnt   <= sat_add(r_fwd_cnt, w_nfwd);
    end
  end

  assign stall     = w_stall;
  assign fwd_a     = r_fwd_a;
  assign fwd_b     = r_fwd_b;
  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized bench for hazard_scoreboard against an in-flight
// instruction list model built from the hazard/forwarding rules.
module tb_hazard_scoreboard;

  localparam int RW    = 5;
  localparam int DEPTH = 3;
  localparam int LS    = 2;
  localparam int FN    = 2;
  localparam int CW    = 8;
  localparam int SW    = 2;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          t_reset = 1'b1;
  logic          t_v = 1'b0;
  logic [RW-1:0] t_rs1 = '0;
  logic [RW-1:0] t_rs2 = '0;
  logic          t_u1 = 1'b0;
  logic          t_u2 = 1'b0;
  logic [RW-1:0] t_rd = '0;
  logic          t_we = 1'b0;
  logic          t_ld = 1'b0;
  logic          t_fl = 1'b0;
  logic          stall;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] fwd_cnt;

  hazard_scoreboard #(.RW(RW), .DEPTH(DEPTH), .LOAD_STAGE(LS), .FLUSH_N(FN), .CW(CW)) dut (
    .clk(clk), .reset(t_reset), .id_valid(t_v), .id_rs1(t_rs1), .id_rs2(t_rs2),
    .id_use1(t_u1), .id_use2(t_u2), .id_rd(t_rd), .id_we(t_we), .id_load(t_ld),
    .flush(t_fl), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  // Model: in-flight writers, index 1 = just left ID (EX), DEPTH = WB.
  bit mv  [1:DEPTH];
  bit mwe [1:DEPTH];
  bit mld [1:DEPTH];
  int mrd [1:DEPTH];
  int mfa, mfb, msc, mfc;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int saved;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int youngest(input int r);
    for (int s = 1; s <= DEPTH; s++)
      if (mv[s] && mwe[s] && mrd[s] == r && r != 0) return s;
    return 0;
  endfunction

  function automatic bit m_hazard(input bit use_r, input int r);
    int y;
    y = youngest(r);
    return use_r && y != 0 && mld[y] && y < LS;
  endfunction

  function automatic bit m_stall();
    return t_v && !t_fl && (m_hazard(t_u1, int'(t_rs1)) || m_hazard(t_u2, int'(t_rs2)));
  endfunction

  function automatic int m_fwd(input bit use_r, input int r);
    int y;
    y = youngest(r);
    if (!t_v || m_stall() || t_fl || !use_r || y == 0 || y >= DEPTH) return 0;
    return y + 1;
  endfunction

  task automatic model_edge();
    bit st;
    int na, nb;
    if (t_reset) begin
      for (int s = 1; s <= DEPTH; s++) mv[s] = 0;
      mfa = 0; mfb = 0; msc = 0; mfc = 0;
      return;
    end
    st = m_stall();
    na = m_fwd(t_u1, int'(t_rs1));
    nb = m_fwd(t_u2, int'(t_rs2));
    msc = (msc + int'(st) > MAXC) ? MAXC : msc + int'(st);
    mfc = (mfc + int'(na != 0) + int'(nb != 0) > MAXC) ? MAXC
          : mfc + int'(na != 0) + int'(nb != 0);
    mfa = na;
    mfb = nb;
    for (int s = DEPTH; s >= 2; s--) begin
      if (t_fl && s - 1 <= FN) mv[s] = 0;
      else mv[s] = mv[s-1];
      mwe[s] = mwe[s-1]; mld[s] = mld[s-1]; mrd[s] = mrd[s-1];
    end
    mv[1] = t_v && !st && !t_fl;
    mwe[1] = t_we; mld[1] = t_ld; mrd[1] = int'(t_rd);
  endtask

  // Compare mid-cycle, then advance one edge; returns 1 time unit after it.
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      chk("m_stall", {31'd0, stall}, {31'd0, m_stall()});
      chk("m_fwd_a", {30'd0, fwd_a}, mfa);
      chk("m_fwd_b", {30'd0, fwd_b}, mfb);
      chk("m_stall_cnt", {24'd0, stall_cnt}, msc);
      chk("m_fwd_cnt", {24'd0, fwd_cnt}, mfc);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit we, input bit ld, input bit fl);
    t_v = v; t_rs1 = RW'(rs1); t_rs2 = RW'(rs2); t_u1 = u1; t_u2 = u2;
    t_rd = RW'(rd); t_we = we; t_ld = ld; t_fl = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    t_reset = 1'b1;
    step();
    t_reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("reset_stall", {31'd0, stall}, 0);
    chk("reset_fwd_a", {30'd0, fwd_a}, 0);
    chk("reset_cnt", {24'd0, stall_cnt}, 0);

    // 1: ALU producer then ALU consumer
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); step();
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
    chk("t1_stall", {31'd0, stall}, 0);
    step();
    chk("t1_fwd_a", {30'd0, fwd_a}, 2);
    chk("t1_fwd_b", {30'd0, fwd_b}, 2);

    // 2: load-use
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0); step();
    drive(1, 1, 4, 1, 1, 3, 1, 0, 0);
    chk("t2_stall", {31'd0, stall}, 1);
    step();
    chk("t2_stall_after", {31'd0, stall}, 0);
    chk("t2_stall_cnt", {24'd0, stall_cnt}, 1);
    step();
    chk("t2_fwd_a", {30'd0, fwd_a}, 3);
    chk("t2_fwd_b", {30'd0, fwd_b}, 0);

    // 3: $0 never matches; unused operand ignored
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(1, 0, 0, 1, 0, 6, 1, 0, 0);
    chk("t3_r0_stall", {31'd0, stall}, 0);
    step();
    chk("t3_r0_fwd_a", {30'd0, fwd_a}, 0);
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0); step();
    drive(1, 0, 5, 0, 0, 7, 1, 0, 0);
    chk("t3_unused_stall", {31'd0, stall}, 0);
    step();
    chk("t3_unused_fwd_b", {30'd0, fwd_b}, 0);

    // 4: youngest match (load) wins over older ALU write
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0); step();
    drive(1, 1, 0, 1, 0, 8, 1, 0, 0);
    chk("t4_stall", {31'd0, stall}, 1);
    step();
    chk("t4_stall_after", {31'd0, stall}, 0);
    step();
    chk("t4_fwd_a", {30'd0, fwd_a}, 3);

    // 5: flush beats stall and empties slots
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0); step();
    saved = int'(stall_cnt);
    drive(1, 1, 0, 1, 0, 9, 1, 0, 1);
    chk("t5_stall", {31'd0, stall}, 0);
    step();
    chk("t5_fwd_a", {30'd0, fwd_a}, 0);
    chk("t5_stall_cnt", {24'd0, stall_cnt}, saved);
    drive(1, 1, 1, 1, 1, 9, 1, 0, 0);
    chk("t5_empty_stall", {31'd0, stall}, 0);
    step();
    chk("t5_empty_fwd_a", {30'd0, fwd_a}, 0);

    // 6: counter saturation, then reset mid-stall
    do_reset();
    for (int i = 0; i < MAXC + 4; i++) begin
      drive(1, 0, 0, 0, 0, 1, 1, 1, 0); step();
      drive(1, 1, 0, 1, 0, 2, 1, 0, 0); step();
    end
    chk("t6_sat", {24'd0, stall_cnt}, MAXC);
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0); step();
    drive(1, 1, 0, 1, 0, 2, 1, 0, 0);
    chk("t6_pre_reset_stall", {31'd0, stall}, 1);
    t_reset = 1'b1;
    step();
    t_reset = 1'b0;
    #1;
    chk("t6_post_reset_stall", {31'd0, stall}, 0);
    chk("t6_post_reset_scnt", {24'd0, stall_cnt}, 0);
    chk("t6_post_reset_fcnt", {24'd0, fwd_cnt}, 0);

    // Randomized traffic over a small register set to provoke matches
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 9) == 0);
      t_reset = ($urandom_range(0, 49) == 0);
      step();
    end
    t_reset = 1'b0;
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
